// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions used by the receiver and reusable by the
//   transmitter: frame width, FSM state encoding, and helpers that derive
//   the bit-period divider and counter width from clock/baud parameters.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Data bits per 8N1 frame.
    localparam int UART_DATA_BITS = 8;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BRK   = 3'd4
    } uart_state_t;

    // Clock cycles per bit period.
    function automatic int uart_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Width of a down-counter that must hold values up to div-1.
    function automatic int uart_cnt_w(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Receive FIFO, first-word fall-through. The head entry is presented
//   combinationally on o_head. A push while full is accepted only when a
//   pop happens in the same cycle (the slot frees up on the same edge);
//   otherwise the byte is dropped and the caller flags the overflow.
//   Pops while empty are ignored.
//
//   Ports:
//     clk      in   system clock, rising edge
//     resetn   in   synchronous active-low reset (pointers/count only)
//     i_push   in   write request
//     i_data   in   WIDTH-bit write data
//     i_pop    in   read request (ignored when empty)
//     o_head   out  head entry (stable but meaningless when empty)
//     o_full   out  FIFO holds FIFO_DEPTH entries
//     o_empty  out  FIFO holds no entries
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;

    logic w_pop;
    logic w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_pop   = i_pop && !o_empty;
    // Full + simultaneous pop: the freed slot is the one being written.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_head  = r_mem[r_rptr];

    // Depth is a power of two, so natural pointer overflow is the wrap.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; contents are only observable when non-empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/uart_rx_io.sv
// -----------------------------------------------------------------------------
// uart_rx_io
//   8N1 UART receiver with a CPU-facing receive FIFO and sticky error flags.
//   The line is resynchronized by two flops, the start bit is confirmed at
//   its midpoint, and each data/stop bit is sampled one bit period later.
//   A low stop bit is a framing error: the byte is discarded and the FSM
//   parks in BRK until the line returns high, so a held-low line (break)
//   never launches a new frame.
//
//   Ports:
//     clk      in   system clock, rising edge
//     resetn   in   synchronous active-low reset
//     uart_rx  in   asynchronous serial line, idle high, LSB first
//     io_rd    in   pop FIFO head (ignored when o_valid=0)
//     clr_err  in   clear o_ferr/o_ovf (a same-cycle new error wins)
//     o_data   out  FIFO head byte, first-word fall-through
//     o_valid  out  FIFO non-empty
//     o_ferr   out  sticky framing-error flag
//     o_ovf    out  sticky overflow flag (byte dropped, FIFO full)
//     o_busy   out  receiver FSM not idle
// -----------------------------------------------------------------------------
module uart_rx_io
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 10000000,
    parameter int BAUD_RATE   = 1000000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       uart_rx,
    input  logic       io_rd,
    input  logic       clr_err,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_ferr,
    output logic       o_ovf,
    output logic       o_busy
);

    localparam int DIV   = uart_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CNT_W = uart_cnt_w(DIV);
    // Half a bit lands the start-bit check mid-bit; full bits step from there.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV/2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);

    // ---------------- line synchronizer ----------------
    logic [1:0] r_sync;
    logic       w_rx_s;

    always_ff @(posedge clk) begin
        if (!resetn) r_sync <= 2'b11;
        else         r_sync <= {r_sync[0], uart_rx};
    end

    assign w_rx_s = r_sync[1];

    // ---------------- receiver FSM ----------------
    uart_state_t               r_state;
    uart_state_t               w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic [2:0]                r_idx;
    logic [2:0]                w_idx_nxt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] w_shift_nxt;
    logic                      w_push;
    logic                      w_ferr_set;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_ferr_set  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    w_cnt_nxt   = CNT_HALF;
                    w_state_nxt = ST_START;
                end
            end

            ST_START: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (!w_rx_s) begin
                    w_cnt_nxt   = CNT_FULL;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end else begin
                    // Line went back high before mid-bit: treat as a glitch.
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_DATA: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    // Right shift with new bit at MSB assembles LSB-first data.
                    w_shift_nxt = {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
                    w_cnt_nxt   = CNT_FULL;
                    w_idx_nxt   = r_idx + 1'b1;
                    if (r_idx == 3'd7) w_state_nxt = ST_STOP;
                end
            end

            ST_STOP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (w_rx_s) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_ferr_set  = 1'b1;
                    w_state_nxt = ST_BRK;
                end
            end

            ST_BRK: begin
                if (w_rx_s) w_state_nxt = ST_IDLE;
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_busy = (r_state != ST_IDLE);

    // ---------------- receive FIFO ----------------
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_ovf_set;

    assign w_pop     = io_rd && !w_empty;
    // Only a push that finds the FIFO full with no pop alongside loses data.
    assign w_ovf_set = w_push && w_full && !w_pop;

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (UART_DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (w_pop),
        .o_head  (o_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_valid = !w_empty;

    // ---------------- sticky error flags ----------------
    logic r_ferr;
    logic r_ovf;

    // Set takes priority over clear so an error in the clear cycle survives.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ferr <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_ferr_set)   r_ferr <= 1'b1;
            else if (clr_err) r_ferr <= 1'b0;

            if (w_ovf_set)    r_ovf <= 1'b1;
            else if (clr_err) r_ovf <= 1'b0;
        end
    end

    assign o_ferr = r_ferr;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_uart_rx_io.sv
module tb_uart_rx_io;

    localparam int CLK_HZ  = 10_000_000;
    localparam int BAUD    = 1_000_000;
    localparam int DEPTH   = 4;
    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int FRAME   = 10 * BIT_CYC;

    logic       clk = 1'b0;
    logic       resetn;
    logic       uart_rx;
    logic       io_rd;
    logic       clr_err;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_ferr;
    logic       o_ovf;
    logic       o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: received bytes and sticky flags.
    logic [7:0] model_q[$];
    logic       m_ferr;
    logic       m_ovf;

    always #5 clk = ~clk;

    uart_rx_io #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD_RATE   (BAUD),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .uart_rx (uart_rx),
        .io_rd   (io_rd),
        .clr_err (clr_err),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ferr  (o_ferr),
        .o_ovf   (o_ovf),
        .o_busy  (o_busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame starting just after a rising edge ("cycle 0").
    // Optional one-cycle pulses land on the named edge relative to the start:
    // io_rd (rd_edge), clr_err (clr_edge), resetn low (rst_edge). len < FRAME
    // abandons the frame early.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int len,
                              input int rd_edge, input int clr_edge, input int rst_edge);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int c = 0; c < len; c++) begin
            uart_rx = bits[c / BIT_CYC];
            io_rd   = (c == rd_edge - 1);
            clr_err = (c == clr_edge - 1);
            resetn  = (c != rst_edge - 1);
            @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
        io_rd   = 1'b0;
        clr_err = 1'b0;
        resetn  = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input logic stop);
        send_frame(b, stop, FRAME, -1, -1, -1);
    endtask

    task automatic do_read(output logic [7:0] got, output logic was_valid);
        got       = o_data;
        was_valid = o_valid;
        io_rd = 1'b1;
        @(posedge clk);
        #1;
        io_rd = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, o_valid, model_q.size() != 0);
        if (model_q.size() != 0) chk({tag, "_data"}, o_data, model_q[0]);
        chk({tag, "_ferr"}, o_ferr, m_ferr);
        chk({tag, "_ovf"},  o_ovf,  m_ovf);
        chk({tag, "_busy"}, o_busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[6];
        logic [7:0] got;
        logic       vv;
        int         rise;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0};
        vecs[5] = '{8'h5A, 1'b0, 1'b0, 8'h00, 1'b1};

        resetn  = 1'b0;
        uart_rx = 1'b1;
        io_rd   = 1'b0;
        clr_err = 1'b0;
        idle(3);
        resetn = 1'b1;
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_ferr",  o_ferr,  1'b0);
        chk("rst_ovf",   o_ovf,   1'b0);
        chk("rst_busy",  o_busy,  1'b0);
        idle(2);

        // Start edge at cycle 0, byte expected around cycle 98.
        rise = -1;
        fork
            frame(8'hA5, 1'b1);
            begin
                for (int c = 0; c < FRAME + 10; c++) begin
                    @(negedge clk);
                    if (o_valid && rise < 0) rise = c;
                end
            end
        join
        chk("lat_window", (rise >= 97 && rise <= 99), 1'b1);
        chk("lat_data", o_data, 8'hA5);
        do_read(got, vv);
        chk("lat_rd_empty", o_valid, 1'b0);
        idle(3);

        // Table of single frames.
        for (int i = 0; i < 6; i++) begin
            frame(vecs[i].data, vecs[i].stop);
            idle(5);
            chk("vec_valid", o_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) chk("vec_data", o_data, vecs[i].exp_data);
            chk("vec_ferr", o_ferr, vecs[i].exp_ferr);
            chk("vec_busy", o_busy, 1'b0);
            if (o_valid) do_read(got, vv);
            pulse_clr();
            chk("vec_clr", o_ferr, 1'b0);
            chk("vec_empty", o_valid, 1'b0);
        end

        // Short low glitch is rejected.
        uart_rx = 1'b0;
        idle(3);
        uart_rx = 1'b1;
        chk("glitch_busy", o_busy, 1'b1);
        idle(10);
        chk("glitch_idle",  o_busy,  1'b0);
        chk("glitch_valid", o_valid, 1'b0);
        chk("glitch_ferr",  o_ferr,  1'b0);

        // Bad stop bit followed by held-low line (break).
        frame(8'h3C, 1'b0);
        uart_rx = 1'b0;
        chk("brk_ferr",  o_ferr,  1'b1);
        chk("brk_valid", o_valid, 1'b0);
        idle(30);
        chk("brk_busy", o_busy, 1'b1);
        uart_rx = 1'b1;
        idle(5);
        chk("brk_idle", o_busy, 1'b0);
        chk("brk_ferr_sticky", o_ferr, 1'b1);
        pulse_clr();
        chk("brk_clr", o_ferr, 1'b0);

        // Clear asserted on the very edge that sets a framing error: set wins.
        send_frame(8'h3C, 1'b0, FRAME, -1, 98, -1);
        idle(4);
        chk("setwins_ferr", o_ferr, 1'b1);
        pulse_clr();
        chk("setwins_clr", o_ferr, 1'b0);

        // Five frames with no reads: fifth is dropped.
        for (int i = 1; i <= 5; i++) begin
            frame(8'(i), 1'b1);
            idle(4);
        end
        chk("ovf_set", o_ovf, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            do_read(got, vv);
            chk("ovf_rd_valid", vv, 1'b1);
            chk("ovf_rd_data", got, 8'(i));
        end
        chk("ovf_drained", o_valid, 1'b0);
        do_read(got, vv);
        chk("rd_empty_ignored", o_valid, 1'b0);
        frame(8'h66, 1'b1);
        idle(4);
        chk("after_empty_rd_data", o_data, 8'h66);
        do_read(got, vv);
        chk("after_empty_rd_valid", o_valid, 1'b0);
        pulse_clr();
        chk("ovf_clr", o_ovf, 1'b0);

        // Full FIFO with a read on the stop-sample edge: no overflow.
        for (int i = 1; i <= 4; i++) begin
            frame(8'(i), 1'b1);
            idle(4);
        end
        send_frame(8'h05, 1'b1, FRAME, 98, -1, -1);
        idle(4);
        chk("rdpush_ovf", o_ovf, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            do_read(got, vv);
            chk("rdpush_valid", vv, 1'b1);
            chk("rdpush_data", got, 8'(i));
        end
        chk("rdpush_drained", o_valid, 1'b0);

        // Reset mid-frame (FIFO also holds a byte), then a clean frame.
        frame(8'h99, 1'b1);
        idle(4);
        send_frame(8'h77, 1'b1, 56, -1, -1, 55);
        chk("midrst_valid", o_valid, 1'b0);
        chk("midrst_busy",  o_busy,  1'b0);
        idle(10);
        frame(8'h12, 1'b1);
        idle(4);
        chk("midrst_rx_valid", o_valid, 1'b1);
        chk("midrst_rx_data",  o_data,  8'h12);
        chk("midrst_ferr", o_ferr, 1'b0);
        chk("midrst_ovf",  o_ovf,  1'b0);
        do_read(got, vv);
        chk("midrst_only_one", o_valid, 1'b0);

        // Randomized traffic against the queue model.
        model_q.delete();
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
        for (int it = 0; it < 40; it++) begin
            logic [7:0] b;
            logic       stop;
            int         nrd;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            frame(b, stop);
            idle(4);
            if (!stop)                     m_ferr = 1'b1;
            else if (model_q.size() < DEPTH) model_q.push_back(b);
            else                           m_ovf = 1'b1;
            check_model("rnd_frame");
            nrd = $urandom_range(0, 2);
            for (int r = 0; r < nrd; r++) begin
                do_read(got, vv);
                chk("rnd_rd_valid", vv, model_q.size() != 0);
                if (model_q.size() != 0) begin
                    chk("rnd_rd_data", got, model_q[0]);
                    void'(model_q.pop_front());
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                pulse_clr();
                m_ferr = 1'b0;
                m_ovf  = 1'b0;
            end
            check_model("rnd_post");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
